// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle between decode/writeback (master) and the register file (slave).
//   Read  : rd_en, rd_adr[NRD*AW] -> rd_data[NRD*XLEN], rd_busy[NRD] (registered)
//   Write : wr_en, wr_adr, wr_data
//   Score : rsv_en, rsv_adr, flush -> busy_vec[NREGS]
interface regfile_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned NRD   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                rd_en;
    logic [NRD*AW-1:0]   rd_adr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_adr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_adr;
    logic                flush;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_en, rd_adr, wr_en, wr_adr, wr_data, rsv_en, rsv_adr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_en, rd_adr, wr_en, wr_adr, wr_data, rsv_en, rsv_adr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: NREGS x XLEN register file with NRD registered read ports, one write port and a
// per-register pending scoreboard. Register 0 reads as zero and is never pending.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : regfile_sb_if.slave (read, write, reserve, flush, busy_vec)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data (and the updated
// pending bit) to a read port whose address matches the write.
module regfile_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 16,
    parameter int unsigned NRD   = 2
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    pend_q, pend_d;
    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NRD-1:0]      rd_busy_q, rd_busy_d;
    logic [AW-1:0]       port_adr [NRD];
    logic                wr_hit;

    assign wr_hit = bus.wr_en && (bus.wr_adr != '0);

    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            port_adr[p] = bus.rd_adr[p*AW +: AW];
        end
    end

    // Data update; entry 0 is forced to zero so reads of x0 need no special case.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr_hit) begin
            regs_d[bus.wr_adr] = bus.wr_data;
        end
        regs_d[0] = '0;
    end

    // Pending update: later assignments win, giving flush > reserve > write-clear.
    always_comb begin
        pend_d = pend_q;
        if (wr_hit) begin
            pend_d[bus.wr_adr] = 1'b0;
        end
        if (bus.rsv_en && (bus.rsv_adr != '0)) begin
            pend_d[bus.rsv_adr] = 1'b1;
        end
        if (bus.flush) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        if (bus.rd_en) begin
            for (int p = 0; p < NRD; p++) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_hit && (port_adr[p] == bus.wr_adr)) begin
                    rd_data_d[p*XLEN +: XLEN] = bus.wr_data;
                    rd_busy_d[p]              = pend_d[port_adr[p]];
                end else begin
                    rd_data_d[p*XLEN +: XLEN] = regs_q[port_adr[p]];
                    rd_busy_d[p]              = pend_q[port_adr[p]];
                end
`else
                rd_data_d[p*XLEN +: XLEN] = regs_q[port_adr[p]];
                rd_busy_d[p]              = pend_q[port_adr[p]];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_vec = pend_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed-vector bench for regfile_sb (XLEN=32, NREGS=16, NRD=2).
module tb_regfile_sb;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    regfile_sb_if #(.XLEN(32), .NREGS(16), .NRD(2)) bus ();

    regfile_sb #(.XLEN(32), .NREGS(16), .NRD(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rsv_en  = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        idle();
        bus.wr_en = 1'b1; bus.wr_adr = a; bus.wr_data = d;
        tick();
        idle();
    endtask

    task automatic rsv(input logic [3:0] a);
        idle();
        bus.rsv_en = 1'b1; bus.rsv_adr = a;
        tick();
        idle();
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        idle();
        bus.rd_en = 1'b1; bus.rd_adr = {a1, a0};
        tick();
        idle();
    endtask

    logic [31:0] byp_exp;

    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b0;
        idle();
        bus.rd_adr = '0; bus.wr_adr = '0; bus.wr_data = '0; bus.rsv_adr = '0;
        repeat (3) tick();
        check_val("rst_data", {32'h0, bus.rd_data}, 64'h0);
        check_val("rst_bvec", {48'h0, bus.busy_vec}, 64'h0);
        reset = 1'b1;
        tick();

        // Every address reads zero and not busy after reset.
        for (int a = 0; a < 16; a += 2) begin
            rd(4'(a), 4'(a + 1));
            check_val("init_data", {32'h0, bus.rd_data}, 64'h0);
            check_val("init_busy", {62'h0, bus.rd_busy}, 64'h0);
        end
        check_val("init_bvec", {48'h0, bus.busy_vec}, 64'h0);

        // Write then read on the following cycle; x0 ignores writes.
        wr(4'd5, 32'hDEADBEEF);
        rd(4'd5, 4'd0);
        check_val("wr_x5", {32'h0, bus.rd_data[31:0]}, 64'hDEADBEEF);
        wr(4'd0, 32'h1234);
        rd(4'd0, 4'd0);
        check_val("wr_x0_p0", {32'h0, bus.rd_data[31:0]}, 64'h0);
        check_val("wr_x0_p1", {32'h0, bus.rd_data[63:32]}, 64'h0);
        rsv(4'd0);
        check_val("rsv_x0", {48'h0, bus.busy_vec}, 64'h0);

        // Scoreboard: reserve, then write clears it.
        rsv(4'd3);
        rd(4'd3, 4'd5);
        check_val("rsv_busy", {62'h0, bus.rd_busy}, 64'h1);
        check_val("rsv_bvec", {48'h0, bus.busy_vec}, 64'h0008);
        wr(4'd3, 32'h55);
        rd(4'd3, 4'd3);
        check_val("clr_data", {32'h0, bus.rd_data[31:0]}, 64'h55);
        check_val("clr_busy", {62'h0, bus.rd_busy}, 64'h0);
        check_val("clr_bvec", {48'h0, bus.busy_vec}, 64'h0);

        // Same-cycle write and reserve: data lands, pending stays set.
        idle();
        bus.wr_en = 1'b1; bus.wr_adr = 4'd3; bus.wr_data = 32'h66;
        bus.rsv_en = 1'b1; bus.rsv_adr = 4'd3;
        tick();
        idle();
        check_val("wrrsv_bvec", {48'h0, bus.busy_vec}, 64'h0008);
        rd(4'd3, 4'd3);
        check_val("wrrsv_data", {32'h0, bus.rd_data[63:32]}, 64'h66);
        check_val("wrrsv_busy", {62'h0, bus.rd_busy}, 64'h3);

        // Flush with a coincident reserve clears everything; data untouched.
        wr(4'd1, 32'h101);
        wr(4'd2, 32'h202);
        wr(4'd7, 32'h707);
        rsv(4'd1);
        rsv(4'd2);
        rsv(4'd7);
        check_val("pre_flush", {48'h0, bus.busy_vec}, 64'h008E);
        idle();
        bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_adr = 4'd4;
        tick();
        idle();
        check_val("flush_bvec", {48'h0, bus.busy_vec}, 64'h0);
        rd(4'd1, 4'd2);
        check_val("flush_x1", {32'h0, bus.rd_data[31:0]}, 64'h101);
        check_val("flush_x2", {32'h0, bus.rd_data[63:32]}, 64'h202);
        rd(4'd7, 4'd3);
        check_val("flush_x7", {32'h0, bus.rd_data[31:0]}, 64'h707);
        check_val("flush_x3", {32'h0, bus.rd_data[63:32]}, 64'h66);

        // Same-cycle write/read of x9 on both ports.
        wr(4'd9, 32'h11);
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h11;
`endif
        idle();
        bus.wr_en = 1'b1; bus.wr_adr = 4'd9; bus.wr_data = 32'hA5A5A5A5;
        bus.rd_en = 1'b1; bus.rd_adr = {4'd9, 4'd9};
        tick();
        idle();
        check_val("byp_p0", {32'h0, bus.rd_data[31:0]}, {32'h0, byp_exp});
        check_val("byp_p1", {32'h0, bus.rd_data[63:32]}, {32'h0, byp_exp});
        check_val("byp_busy", {62'h0, bus.rd_busy}, 64'h0);
        rd(4'd9, 4'd9);
        check_val("byp_after", {32'h0, bus.rd_data[31:0]}, 64'hA5A5A5A5);

        // Hold: rd_en low keeps outputs while x5 is rewritten.
        rd(4'd5, 4'd9);
        for (int i = 0; i < 3; i++) begin
            idle();
            bus.rd_adr = {4'd5, 4'd5};
            bus.wr_en = 1'b1; bus.wr_adr = 4'd5; bus.wr_data = 32'hC0DE0000 + 32'(i);
            tick();
            check_val("hold_p0", {32'h0, bus.rd_data[31:0]}, 64'hDEADBEEF);
            check_val("hold_p1", {32'h0, bus.rd_data[63:32]}, 64'hA5A5A5A5);
        end
        rd(4'd5, 4'd5);
        check_val("hold_new", {32'h0, bus.rd_data[31:0]}, 64'hC0DE0002);

        // Asynchronous reset between edges, with a write pending in that cycle.
        rsv(4'd6);
        rsv(4'd6);
        rd(4'd6, 4'd5);
        check_val("pre_rst_busy", {62'h0, bus.rd_busy}, 64'h1);
        idle();
        bus.wr_en = 1'b1; bus.wr_adr = 4'd10; bus.wr_data = 32'hBAD0BAD0;
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_data", {32'h0, bus.rd_data}, 64'h0);
        check_val("arst_busy", {62'h0, bus.rd_busy}, 64'h0);
        check_val("arst_bvec", {48'h0, bus.busy_vec}, 64'h0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        rd(4'd10, 4'd5);
        check_val("arst_x10", {32'h0, bus.rd_data[31:0]}, 64'h0);
        check_val("arst_x5", {32'h0, bus.rd_data[63:32]}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the RISC-V core, replacing the fixed 16x32, two-read-port file. It provides NRD registered read ports, one write port, a per-register pending scoreboard for multi-cycle results (loads, multiplies) and an optional same-cycle write-to-read bypass. It sits between decode, which drives the read addresses and reservations, and writeback, which drives the write port.

## Interface
- XLEN, 32: register width in bits.
- NREGS, 16: number of architectural registers; power of two, at least 2. Register 0 is hardwired to zero.
- NRD, 2: number of read ports, 1 to 4.
- AW, $clog2(NREGS): derived address width; not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_en  in  1  read capture enable; 0 holds all read outputs.
- rd_adr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  registered read data; port i uses bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  registered per port; 1 means the captured value is stale because the register is pending.
- wr_en  in  1  write enable.
- wr_adr  in  AW  write address.
- wr_data  in  XLEN  write data.
- rsv_en  in  1  reserve request; marks rsv_adr as pending.
- rsv_adr  in  AW  address to reserve.
- flush  in  1  clears all pending bits.
- busy_vec  out  NREGS  current pending bits, straight from the flops; bit 0 is always 0.

## Operation
- Storage: NREGS x XLEN flops plus an NREGS-bit pending vector.
- Register 0:
  - Writes to address 0 are ignored.
  - Reservations of address 0 are ignored.
  - Reads of address 0 return 0 with busy 0.
- Write (wr_en=1, wr_adr≠0):
  - The register takes wr_data at the edge.
  - The pending bit of wr_adr is cleared.
- Reserve (rsv_en=1, rsv_adr≠0): the pending bit of rsv_adr is set.
- Pending-bit priority for one address in one cycle: flush, then reserve, then write-clear.
  - Write and reserve to the same address: the data is written and the bit ends set.
  - Flush with reserve: all bits end clear and the reservation is dropped.
  - Flush does not affect data.
- Read (rd_en=1): each port captures the register value and pending state for its address at the edge.
- Read (rd_en=0): rd_data and rd_busy hold their values. Writes, reserves and flushes still take effect.
- Multiple ports may read the same address; all ports return identical results.
- Reset assertion (asynchronous, at any time, including mid-write):
  - All registers go to 0.
  - The pending vector, busy_vec, rd_data and rd_busy go to 0.
  - Any write in that cycle is lost.
- Reset deassertion: normal operation from the first rising edge after it.

## Timing
- Read latency: 1 cycle. An address presented in cycle n with rd_en=1 appears on rd_data and rd_busy after edge n.
- Write visibility: a write at edge n is returned by a read presented in cycle n+1.
- A read in the same cycle as a write to the same address depends on REGFILE_BYPASS_EN (see Configuration).
- busy_vec reflects an update one edge after wr_en, rsv_en or flush.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose address equals wr_adr while wr_en=1 and wr_adr≠0 captures:
  - wr_data;
  - the post-update pending bit for that address. This is 0 unless a reserve of the same address (without flush) occurs that cycle.
- REGFILE_BYPASS_EN undefined:
  - The port captures the old register contents and the pre-update pending bit.
  - The write is visible one cycle later.
  - No wr_data-to-read mux is synthesised.

## Test plan
- Reset: hold reset=0, then release. Reading every address returns 0 with rd_busy=0, and busy_vec=0.
- Write then read:
  - Write 0xDEADBEEF to x5 at edge n, then read x5 on port 0 in cycle n+1. rd_data=0xDEADBEEF one cycle later.
  - Write 0x1234 to x0, then read x0. rd_data=0.
- Scoreboard:
  - Reserve x3, then read x3. rd_busy[0]=1 and busy_vec[3]=1.
  - Write 0x55 to x3, then read again. rd_data=0x55 and rd_busy=0.
  - Same-cycle write and reserve of x3 leaves busy_vec[3]=1.
- Flush:
  - Reserve x1, x2 and x7, then pulse flush together with a reserve of x4. busy_vec=0 next cycle.
  - Data in those registers is unchanged.
- Bypass: write 0xA5A5A5A5 to x9 with x9 on ports 0 and 1 in the same cycle, x9 previously 0x11.
  - With REGFILE_BYPASS_EN: both ports return 0xA5A5A5A5.
  - Without REGFILE_BYPASS_EN: both ports return 0x11.
- Hold and async reset:
  - With rd_en=0 for 3 cycles while x5 is rewritten, rd_data stays at the old value.
  - Asserting reset between edges drives rd_data to 0 immediately, without waiting for a clock edge.
